// File: rtl/filter_accumulator_bank.sv
// Multi-channel signed accumulator bank fed by a channel-tagged sample stream.
// A dump request snapshots and clears every accumulator in one cycle, then the
// snapshot drains over a valid/ready port while accumulation carries on.
module filter_accumulator_bank #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 20,
  localparam int unsigned CH_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     in_load,
  input  logic signed [DATA_W-1:0] D,
  input  logic                     sat_en,
  input  logic                     dump_req,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [ACC_W-1:0]         Q,
  output logic                     out_ovf
);

  typedef enum logic {StIdle, StDump} state_e;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q    [N_CH];
  logic signed [ACC_W-1:0] acc_d    [N_CH];
  logic signed [ACC_W-1:0] shadow_q [N_CH];
  logic [N_CH-1:0]         ovf_q, ovf_d;
  logic [N_CH-1:0]         shadow_ovf_q;
  logic [CH_W-1:0]         idx_nxt;
  logic                    dump_fire;

  // Returns {ovf, acc} for one channel given its (possibly cleared) base value.
  function automatic logic [ACC_W:0] acc_step(
    input logic signed [ACC_W-1:0]  base,
    input logic                     base_ovf,
    input logic                     hit,
    input logic                     load,
    input logic                     sat,
    input logic signed [DATA_W-1:0] smp
  );
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] ext;
    logic [ACC_W:0]          res;
    ext = ACC_W'(smp);
    sum = (ACC_W+1)'(base) + (ACC_W+1)'(smp);
    res = {base_ovf, base};
    if (hit) begin
      if (load) begin
        res = {1'b0, ext};
      end else if (sum[ACC_W] == sum[ACC_W-1]) begin
        res = {base_ovf, sum[ACC_W-1:0]};
      end else if (!sat) begin
        res = {1'b1, sum[ACC_W-1:0]};
      end else if (sum[ACC_W]) begin
        res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end
    return res;
  endfunction

  assign dump_fire = (state_q == StIdle) && dump_req;
  assign idx_nxt   = out_ch + CH_W'(1);

  // Next accumulator state: a dump clears the bank first, so a same-cycle
  // sample becomes the first sample of the new window.
  always_comb begin
    ovf_d = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      acc_d[c] = '0;
      {ovf_d[c], acc_d[c]} = acc_step(dump_fire ? '0 : acc_q[c],
                                      dump_fire ? 1'b0 : ovf_q[c],
                                      in_valid && (in_ch == CH_W'(c)),
                                      in_load, sat_en, D);
    end
  end

  // Accumulator bank and snapshot registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c]    <= '0;
        shadow_q[c] <= '0;
      end
      ovf_q        <= '0;
      shadow_ovf_q <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c] <= acc_d[c];
        if (dump_fire) shadow_q[c] <= acc_q[c];
      end
      ovf_q <= ovf_d;
      if (dump_fire) shadow_ovf_q <= ovf_q;
    end
  end

  // Readout FSM with registered outputs; out_ch doubles as the readout index.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      Q         <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dump_req) begin
            state_q   <= StDump;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_ch    <= '0;
            // Channel 0 is presented straight from the pre-update bank,
            // which is exactly what the shadow captures this edge.
            Q         <= acc_q[0];
            out_ovf   <= ovf_q[0];
          end
        end
        StDump: begin
          if (out_ready) begin
            if (out_ch == CH_W'(N_CH - 1)) begin
              state_q   <= StIdle;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              out_ch  <= idx_nxt;
              Q       <= shadow_q[idx_nxt];
              out_ovf <= shadow_ovf_q[idx_nxt];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_accumulator_bank.sv
// Directed bench for filter_accumulator_bank with a reference-model scoreboard.
module tb_filter_accumulator_bank;

  localparam int N_CH   = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 20;
  localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));
  localparam longint SPAN = 64'sd1 <<< ACC_W;

  typedef struct {
    int         ch;
    logic [19:0] q;
    logic       ovf;
  } ent_t;

  logic               clk = 1'b0;
  logic               rstb;
  logic               in_valid, in_load, sat_en, dump_req, out_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] D;
  logic               busy, out_valid, out_ovf;
  logic [1:0]         out_ch;
  logic [19:0]        Q;

  int     n_cmp = 0;
  int     n_mis = 0;
  ent_t   sb[$];
  ent_t   got[$];
  longint m_acc [N_CH];
  bit     m_ovf [N_CH];

  logic        prev_stall = 1'b0;
  logic [19:0] prev_q;
  logic [1:0]  prev_ch;
  logic        prev_ovf;

  filter_accumulator_bank #(.N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ch(in_ch), .in_load(in_load),
    .D(D), .sat_en(sat_en), .dump_req(dump_req), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .Q(Q), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one accumulator update, in plain integer arithmetic.
  task automatic m_apply(input int ch, input bit load, input logic [15:0] d);
    longint dv;
    longint s;
    dv = longint'($signed(d));
    if (load) begin
      m_acc[ch] = dv;
      m_ovf[ch] = 1'b0;
    end else begin
      s = m_acc[ch] + dv;
      if (s > MAXV || s < MINV) begin
        m_ovf[ch] = 1'b1;
        if (sat_en) s = (s > MAXV) ? MAXV : MINV;
        else        s = (s > MAXV) ? s - SPAN : s + SPAN;
      end
      m_acc[ch] = s;
    end
  endtask

  task automatic sample(input int ch, input bit load, input logic [15:0] d);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_load  = load;
    D        = d;
    m_apply(ch, load, d);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic m_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
  endtask

  // Raises dump_req for one cycle (optionally with a same-cycle sample).
  task automatic start_dump(input bit smp, input int ch, input bit load, input logic [15:0] d);
    logic [63:0] tmp;
    ent_t        e;
    dump_req = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      tmp   = m_acc[c];
      e.ch  = c;
      e.q   = tmp[19:0];
      e.ovf = m_ovf[c];
      sb.push_back(e);
    end
    m_clear();
    got.delete();
    if (smp) begin
      in_valid = 1'b1;
      in_ch    = 2'(ch);
      in_load  = load;
      D        = d;
      m_apply(ch, load, d);
    end
    cyc();
    dump_req = 1'b0;
    in_valid = 1'b0;
    chk("dump_valid", 32'(out_valid), 1);
    chk("dump_busy", 32'(busy), 1);
    chk("dump_ch0", 32'(out_ch), 0);
  endtask

  // Drains the readout; bp selects the 1,0,0 ready pattern.
  task automatic finish_dump(input bit bp, input int exp_busy);
    int k;
    k = 0;
    while (busy && k < 100) begin
      out_ready = bp ? (k % 3 == 0) : 1'b1;
      cyc();
      k++;
    end
    out_ready = 1'b1;
    chk("dump_timeout", 32'(busy), 0);
    chk("dump_valid_low", 32'(out_valid), 0);
    chk("dump_all_out", 32'(sb.size()), 0);
    if (exp_busy > 0) chk("busy_cycles", 32'(k), 32'(exp_busy));
  endtask

  task automatic chk_got(input string tag, input int i, input logic [19:0] q, input logic ovf);
    chk({tag, "_q"}, (i < got.size()) ? 32'(got[i].q) : 32'hdead_beef, 32'(q));
    chk({tag, "_ovf"}, (i < got.size()) ? 32'(got[i].ovf) : 32'hdead_beef, 32'(ovf));
  endtask

  // Output monitor: scoreboard pop on each transfer, hold check on stalls.
  always @(negedge clk) begin
    ent_t e;
    if (!rstb) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_q", 32'(Q), 32'(prev_q));
        chk("stall_ch", 32'(out_ch), 32'(prev_ch));
        chk("stall_ovf", 32'(out_ovf), 32'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 32'(out_ch), 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("xfer_ch", 32'(out_ch), 32'(e.ch));
          chk("xfer_q", 32'(Q), 32'(e.q));
          chk("xfer_ovf", 32'(out_ovf), 32'(e.ovf));
          e.q   = Q;
          e.ovf = out_ovf;
          got.push_back(e);
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_q     <= Q;
      prev_ch    <= out_ch;
      prev_ovf   <= out_ovf;
    end
  end

  initial begin
    rstb      = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_load   = 1'b0;
    D         = '0;
    sat_en    = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b1;
    m_clear();
    repeat (3) @(posedge clk);
    #2;
    rstb = 1'b1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(Q), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    cyc();

    // Basic load/add and a free-flowing dump.
    sample(0, 1'b1, 16'h000A);
    sample(0, 1'b0, 16'hFFFF);
    sample(0, 1'b0, 16'h0334);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("basic_ch0", 0, 20'h0033D, 1'b0);
    chk_got("basic_ch3", 3, 20'h00000, 1'b0);

    // Saturation, then wrap, then an empty window.
    sat_en = 1'b1;
    sample(1, 1'b1, 16'h7FFF);
    for (int i = 0; i < 16; i++) sample(1, 1'b0, 16'h7FFF);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("sat_ch1", 1, 20'h7FFFF, 1'b1);
    sat_en = 1'b0;
    sample(1, 1'b1, 16'h7FFF);
    for (int i = 0; i < 16; i++) sample(1, 1'b0, 16'h7FFF);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("wrap_ch1", 1, 20'h87FEF, 1'b1);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("empty_ch1", 1, 20'h00000, 1'b0);

    // Backpressure with distinct per-channel values.
    for (int c = 0; c < N_CH; c++) sample(c, 1'b1, 16'(c + 1));
    sample(3, 1'b0, 16'h8000);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b1, 0);
    chk_got("bp_ch2", 2, 20'h00003, 1'b0);
    chk_got("bp_ch3", 3, 20'hF8004, 1'b0);

    // Sample in the same cycle as dump_req lands in the new window.
    sample(2, 1'b1, 16'h0007);
    start_dump(1'b1, 2, 1'b0, 16'h0005);
    finish_dump(1'b0, 4);
    chk_got("same_old_ch2", 2, 20'h00007, 1'b0);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("same_new_ch2", 2, 20'h00005, 1'b0);

    // dump_req during readout is ignored; samples keep accumulating.
    start_dump(1'b0, 0, 1'b0, 16'h0);
    out_ready = 1'b0;
    dump_req  = 1'b1;
    sample(3, 1'b0, 16'h0002);
    dump_req = 1'b0;
    sample(3, 1'b0, 16'h0002);
    sample(3, 1'b0, 16'h0002);
    finish_dump(1'b0, 0);
    chk("ignored_req_busy", 32'(busy), 0);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("busy_adds_ch3", 3, 20'h00006, 1'b0);

    // Asynchronous reset in the middle of a readout.
    sample(1, 1'b1, 16'h0123);
    start_dump(1'b0, 0, 1'b0, 16'h0);
    out_ready = 1'b0;
    sample(0, 1'b1, 16'h0055);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_q", 32'(Q), 0);
    sb.delete();
    m_clear();
    @(posedge clk);
    #2;
    rstb      = 1'b1;
    out_ready = 1'b1;
    cyc();
    start_dump(1'b0, 0, 1'b0, 16'h0);
    finish_dump(1'b0, 4);
    chk_got("post_rst_ch0", 0, 20'h00000, 1'b0);
    chk_got("post_rst_ch1", 1, 20'h00000, 1'b0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
